// File: rtl/x9_pkg.sv
// Shared definitions for the X9 host-side instruction loader.
package x9_pkg;

  localparam int unsigned X9_D   = 12;   // instruction address / PC width
  localparam int unsigned X9_W   = 9;    // instruction word width
  localparam int unsigned X9_TMO = 4096; // run-cycle limit before timeout

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Host word stream plus instruction-RAM write port of the X9 loader.
// The host is the master of the stream; the loader (slave) accepts words
// and drives the RAM write port.
interface instr_loader_if
  import x9_pkg::*;
#(
  parameter int unsigned D = X9_D,
  parameter int unsigned W = X9_W
) ();

  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         im_we;
  logic [D-1:0] im_addr;
  logic [W-1:0] im_wdat;

  modport master (
    output s_valid, s_data,
    input  s_ready, im_we, im_addr, im_wdat
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, im_we, im_addr, im_wdat
  );

endinterface

// File: rtl/instr_loader.sv
// Loads a program into the X9 instruction RAM, releases the core from hold
// and counts run cycles until the core signals done or the limit expires.
module instr_loader
  import x9_pkg::*;
#(
  parameter int unsigned D   = X9_D,
  parameter int unsigned W   = X9_W,
  parameter int unsigned TMO = X9_TMO
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  len,
  instr_loader_if.slave bus,
  output logic          cpu_hold,
  input  logic          cpu_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [31:0]   run_cycles
);

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic [D:0]    r_len;
  logic [D:0]    r_cnt;
  logic [D-1:0]  r_ptr;
  logic          r_im_we;
  logic [D-1:0]  r_im_addr;
  logic [W-1:0]  r_im_wdat;
  logic [31:0]   r_run_cycles;

  logic          w_accept;
  logic          w_launch;
  logic          w_last;
  logic          w_tmo;
  logic [D:0]    w_cnt_inc;

  // Accept qualified by registered state only, so s_ready has no path from s_valid.
  assign w_accept  = bus.s_valid && (r_state == ST_LOAD);
  assign w_cnt_inc = r_cnt + (D+1)'(1);
  assign w_last    = w_accept && (w_cnt_inc == r_len);
  assign w_tmo     = (r_run_cycles == TMO - 1);

  assign bus.im_we   = r_im_we;
  assign bus.im_addr = r_im_addr;
  assign bus.im_wdat = r_im_wdat;
  assign run_cycles  = r_run_cycles;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    bus.s_ready = 1'b0;
    cpu_hold    = 1'b1;
    busy        = 1'b0;
    finished    = 1'b0;
    timed_out   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_launch    = 1'b1;
        end
      end
      ST_LOAD: begin
        bus.s_ready = 1'b1;
        busy        = 1'b1;
        if (w_last) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        busy        = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        busy     = 1'b1;
        if (cpu_done)   w_state_nxt = ST_DONE;
        else if (w_tmo) w_state_nxt = ST_TIMEOUT;
      end
      ST_DONE: begin
        finished = 1'b1;
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_launch    = 1'b1;
        end
      end
      ST_TIMEOUT: begin
        timed_out = 1'b1;
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_launch    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Length latch, write pointer, word count and registered RAM write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_im_we   <= 1'b0;
      r_im_addr <= '0;
      r_im_wdat <= '0;
    end else begin
      r_im_we <= w_accept;
      if (w_accept) begin
        r_im_addr <= r_ptr;
        r_im_wdat <= bus.s_data;
        r_ptr     <= r_ptr + D'(1);
        r_cnt     <= w_cnt_inc;
      end
      if (w_launch) begin
        // len of zero becomes 2^D by setting the extra count bit
        r_len <= {(len == '0), len};
        r_cnt <= '0;
        r_ptr <= '0;
      end
    end
  end

  // Run-cycle counter: cleared on launch, counts every RUN edge, frozen otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_run_cycles <= '0;
    else if (w_launch)           r_run_cycles <= '0;
    else if (r_state == ST_RUN)  r_run_cycles <= r_run_cycles + 32'd1;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Host-side loader and run controller for the X9 core: the writer end of the instruction memory that the core's fetch stage reads. It accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them to consecutive instruction-RAM addresses. It then releases the core from hold and times the run until the core raises `done`. It sits between the testbench/host link and the `top_level` core plus its instruction RAM.

## Interface
Parameters:
- `D`, 12, instruction address / program-counter width
- `W`, 9, instruction word width
- `TMO`, 4096, run-cycle limit before timeout (≥2)

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a load
- `len`  in  D  number of words to load; 0 means 2^D; latched on accepted `start`
- `s_valid`  in  1  host word valid
- `s_data`  in  W  host machine-code word
- `s_ready`  out  1  loader accepts a word this cycle
- `im_we`  out  1  instruction-RAM write enable
- `im_addr`  out  D  instruction-RAM write address
- `im_wdat`  out  W  instruction-RAM write data
- `cpu_hold`  out  1  high holds the core in reset
- `cpu_done`  in  1  core `done` flag (combinational from the core's PC)
- `busy`  out  1  high in LOAD, RELEASE or RUN
- `finished`  out  1  high in DONE
- `timed_out`  out  1  high in TIMEOUT
- `run_cycles`  out  32  cycles spent in RUN; frozen in DONE/TIMEOUT

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE, TIMEOUT.
- IDLE: `start` → LOAD. On that edge: latch `len`, clear word count, clear `im_addr` pointer, clear `run_cycles`.
- LOAD: `s_ready` = 1. Each edge with `s_valid & s_ready` is an accept.
  - An accept registers `im_we`=1, `im_addr`=pointer, `im_wdat`=`s_data` for the next cycle.
  - An accept increments the pointer (D-bit, wraps) and the word count (D+1-bit).
  - The accept making count equal latched len (len 0 → 2^D) → RELEASE.
- RELEASE: one cycle. `cpu_hold` stays 1 while the last write lands. Next state is RUN.
- RUN: `cpu_hold`=0 and `run_cycles` increments every edge.
  - `cpu_done`=1 sampled → DONE.
  - Otherwise, `run_cycles` reaching TMO-1 on this edge → TIMEOUT.
  - `cpu_done` has priority when both hold on the same edge.
- DONE / TIMEOUT: `cpu_hold`=1. `start` → LOAD with the same latching as IDLE. No path back to IDLE except reset.
- `start` is ignored in LOAD, RELEASE and RUN.
- `s_valid` outside LOAD is ignored: no write, no count.
- `im_we` is 0 in every cycle not immediately following an accept.
- Reset (any state, asynchronous) values:
  - state IDLE
  - `s_ready` 0, `im_we` 0, `im_addr` 0, `im_wdat` 0
  - `cpu_hold` 1
  - `busy` 0, `finished` 0, `timed_out` 0
  - `run_cycles` 0
- A partially loaded program is abandoned on reset; the core stays held.

## Timing
- `s_ready` is a pure function of registered state; there is no combinational path from `s_valid`.
- Write latency is 1 cycle: a word accepted at edge k is written to RAM at edge k+1.
- Back-to-back accepts give one write per cycle.
- The last accept at edge k gives RELEASE in cycle k+1 (last write completes at edge k+1).
- RUN starts in cycle k+2, with `cpu_hold` low from that cycle.
- `cpu_done` sampled high at edge m: `cpu_hold` is high from cycle m+1 and `run_cycles` holds its edge-m value.
- `run_cycles` equals the number of RUN edges taken, including the terminating edge.
- `busy`, `finished` and `timed_out` are decoded from registered state.

## Structure
- Shared package `x9_pkg`: `loader_state_t` enum (six states), default constants `X9_D`=12, `X9_W`=9, `X9_TMO`=4096.
- Single flat module; no sub-module is warranted. The state register, pointer/count and run counter are three always_ff processes.

## Test plan
- len=4, words 0x1A0,0x055,0x1FF,0x000 with `s_valid` held high → `im_we` high 4 consecutive cycles at addresses 0..3 with matching data; RELEASE 1 cycle; `cpu_hold` falls in cycle 6 after `start`.
- Same load with `s_valid` toggling 1,0,1,0,… → 4 writes only, addresses still 0..3, no duplicate writes.
- In RUN, raise `cpu_done` on the 15th RUN edge → DONE, `finished`=1, `run_cycles`=15, `cpu_hold`=1; `start` pulse afterwards → LOAD with `run_cycles`=0.
- TMO=8, `cpu_done` never asserted → TIMEOUT after 8 RUN edges, `timed_out`=1, `run_cycles`=8; `cpu_done` and `TMO` hitting together → DONE.
- D=4, len=0 → exactly 16 writes to addresses 0..15; pointer wraps to 0 before RELEASE.
- Assert `reset` low mid-LOAD after 2 of 4 words → all outputs at reset values immediately; `start` and `s_valid` ignored until reset deasserts; a new load starts again at address 0.
